// File: rtl/maj_tt_scanner.sv
// Majority-network truth-table scanner: evaluates up to MAX_NODES programmed
// 3-input majority nodes for all 128 minterms. Define MAJ_TT_ONSET_COUNT_EN to add onset_cnt.
module maj_tt_scanner #(
  parameter int MAX_NODES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prog_we,
  input  logic [2:0]   prog_addr,
  input  logic [14:0]  prog_data,
  input  logic [3:0]   num_nodes,
  input  logic         out_inv,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] tt
`ifdef MAJ_TT_ONSET_COUNT_EN
  ,
  output logic [7:0]   onset_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [14:0]          r_prog [MAX_NODES];
  logic [MAX_NODES-1:0] r_nodes;
  logic [2:0]           r_node_idx;
  logic [2:0]           r_last_idx;
  logic [6:0]           r_minterm;
  logic                 r_out_inv;
  logic                 r_err;
  logic [127:0]         r_tt;
`ifdef MAJ_TT_ONSET_COUNT_EN
  logic [7:0]           r_onset_cnt;
`endif

  logic [7:0]  w_nodes8;
  logic [14:0] w_slot;
  logic        w_a;
  logic        w_b;
  logic        w_c;
  logic        w_maj;
  logic        w_legal;
  logic        w_tt_bit;

  // Node slots beyond MAX_NODES read as constant 0 so sel 8..15 is always defined.
  for (genvar gi = 0; gi < 8; gi++) begin : g_nodes
    if (gi < MAX_NODES) begin : g_used
      assign w_nodes8[gi] = r_nodes[gi];
    end else begin : g_unused
      assign w_nodes8[gi] = 1'b0;
    end
  end

  function automatic logic operand(input logic [4:0] f, input logic [6:0] x,
                                   input logic [7:0] n);
    logic v;
    if (f[3])
      v = n[f[2:0]];
    else if (f[2:0] == 3'd0)
      v = 1'b0;
    else
      v = x[f[2:0] - 3'd1];
    return v ^ f[4];
  endfunction

  // Nodes j >= k are still zero within the current minterm, so no masking is needed.
  assign w_slot   = r_prog[r_node_idx];
  assign w_a      = operand(w_slot[4:0],   r_minterm, w_nodes8);
  assign w_b      = operand(w_slot[9:5],   r_minterm, w_nodes8);
  assign w_c      = operand(w_slot[14:10], r_minterm, w_nodes8);
  assign w_maj    = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
  assign w_tt_bit = w_maj ^ r_out_inv;
  assign w_legal  = (num_nodes != 4'd0) && (num_nodes <= 4'(MAX_NODES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_nodes    <= '0;
      r_node_idx <= '0;
      r_last_idx <= '0;
      r_minterm  <= '0;
      r_out_inv  <= 1'b0;
      r_err      <= 1'b0;
      r_tt       <= '0;
      for (int i = 0; i < MAX_NODES; i++) r_prog[i] <= '0;
`ifdef MAJ_TT_ONSET_COUNT_EN
      r_onset_cnt <= '0;
`endif
    end else begin
      if (prog_we && (r_state != S_EVAL) && (32'(prog_addr) < MAX_NODES))
        r_prog[prog_addr] <= prog_data;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_state    <= S_EVAL;
              r_tt       <= '0;
              r_minterm  <= '0;
              r_node_idx <= '0;
              r_nodes    <= '0;
              r_last_idx <= 3'(num_nodes - 4'd1);
              r_out_inv  <= out_inv;
`ifdef MAJ_TT_ONSET_COUNT_EN
              r_onset_cnt <= '0;
`endif
            end else begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_node_idx == r_last_idx) begin
            r_tt[r_minterm] <= w_tt_bit;
            r_nodes    <= '0;
            r_node_idx <= '0;
            r_minterm  <= r_minterm + 7'd1;
`ifdef MAJ_TT_ONSET_COUNT_EN
            r_onset_cnt <= r_onset_cnt + 8'(w_tt_bit);
`endif
            if (r_minterm == 7'd127) r_state <= S_DONE;
          end else begin
            r_nodes[r_node_idx] <= w_maj;
            r_node_idx <= r_node_idx + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_EVAL);
  assign done = (r_state == S_DONE);
  assign err  = r_err;
  assign tt   = r_tt;
`ifdef MAJ_TT_ONSET_COUNT_EN
  assign onset_cnt = r_onset_cnt;
`endif

endmodule

// File: tb/tb_maj_tt_scanner.sv
// Scoreboard bench for maj_tt_scanner: the driver queues expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_maj_tt_scanner;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         prog_we = 1'b0;
  logic [2:0]   prog_addr = '0;
  logic [14:0]  prog_data = '0;
  logic [3:0]   num_nodes = '0;
  logic         out_inv = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] tt;
`ifdef MAJ_TT_ONSET_COUNT_EN
  logic [7:0]   onset_cnt;
`endif

  always #5 clk = ~clk;

  maj_tt_scanner #(.MAX_NODES(8)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .num_nodes(num_nodes), .out_inv(out_inv),
    .start(start), .abort(abort), .busy(busy), .done(done), .err(err), .tt(tt)
`ifdef MAJ_TT_ONSET_COUNT_EN
    , .onset_cnt(onset_cnt)
`endif
  );

  typedef struct {
    logic [127:0] tt;
    logic         err;
    int           onset;
    int           issue;
    int           lat;
    string        name;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  bit           busy_seen = 1'b0;
  logic [14:0]  prog_mdl [8];
  logic [127:0] last_tt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 128'(done), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_tt"}, tt, mon_e.tt);
        check({mon_e.name, "_err"}, 128'(err), 128'(mon_e.err));
        check({mon_e.name, "_latency"}, 128'(cyc - mon_e.issue), 128'(mon_e.lat));
`ifdef MAJ_TT_ONSET_COUNT_EN
        check({mon_e.name, "_onset"}, 128'(onset_cnt), 128'(mon_e.onset));
`endif
        $display("[TB] txn %s done at +%0d cycles err=%0b", mon_e.name, cyc - mon_e.issue, err);
      end
    end
    if (err && !done) check("err_without_done", 128'(err), 128'(0));
  end

  function automatic logic opnd(input logic [4:0] f, input logic [6:0] x, input logic [7:0] nd);
    int  s;
    logic v;
    s = int'(f[3:0]);
    if (s == 0)     v = 1'b0;
    else if (s < 8) v = x[s-1];
    else            v = nd[s-8];
    return v ^ f[4];
  endfunction

  // Reference network: nodes evaluated in order, unevaluated nodes read 0.
  function automatic logic [127:0] model_tt(input int n, input logic oi);
    logic [127:0] r;
    logic [7:0]   nd;
    logic [6:0]   x;
    logic         a, b, c, res;
    r = '0;
    for (int m = 0; m < 128; m++) begin
      nd  = '0;
      res = 1'b0;
      x   = 7'(m);
      for (int k = 0; k < n; k++) begin
        a = opnd(prog_mdl[k][4:0], x, nd);
        b = opnd(prog_mdl[k][9:5], x, nd);
        c = opnd(prog_mdl[k][14:10], x, nd);
        res = (a & b) | (a & c) | (b & c);
        nd[k] = res;
      end
      r[m] = res ^ oi;
    end
    return r;
  endfunction

  task automatic prog(input int a, input logic [14:0] d);
    prog_addr = 3'(a);
    prog_data = d;
    prog_we   = 1'b1;
    @(negedge clk);
    prog_we   = 1'b0;
    prog_mdl[a] = d;
  endtask

  task automatic issue(input string nm, input int n, input logic oi,
                       input logic [127:0] exp_tt, input logic exp_err, input int lat);
    exp_t x;
    num_nodes = 4'(n);
    out_inv   = oi;
    start     = 1'b1;
    x.name  = nm;
    x.issue = cyc;
    x.tt    = exp_tt;
    x.err   = exp_err;
    x.lat   = lat;
    x.onset = $countones(exp_tt);
    last_tt = exp_tt;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_timeout"}, 128'(sb.size()), 128'(0));
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) prog_mdl[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_tt", tt, 128'(0));
`ifdef MAJ_TT_ONSET_COUNT_EN
    check("rst_onset", 128'(onset_cnt), 128'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // maj(x1,x2,x3)
    prog(0, {5'd4, 5'd3, 5'd2});
    issue("maj_x123", 1, 1'b0, {8{16'hFCC0}}, 1'b0, 129);
    wait_drain("maj_x123");

    // maj(0, x0, ~0) = x0, inverted; abort raised with start (start wins)
    prog(0, {5'h10, 5'd1, 5'd0});
    abort = 1'b1;
    issue("inv_x0", 1, 1'b1, {8{16'h5555}}, 1'b0, 129);
    wait_drain("inv_x0");

    // node1 = maj(node0, x3, ~x4); start and prog_we while busy must be ignored
    prog(0, {5'd3, 5'd2, 5'd1});
    prog(1, {5'h15, 5'd4, 5'd8});
    issue("two_node", 2, 1'b0, model_tt(2, 1'b0), 1'b0, 257);
    repeat (20) @(negedge clk);
    check("busy_mid_scan", 128'(busy), 128'(1));
    num_nodes = 4'd0;
    start     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 3'd1;
    prog_data = 15'h7FFF;
    @(negedge clk);
    start     = 1'b0;
    prog_we   = 1'b0;
    num_nodes = 4'd2;
    wait_drain("two_node");

    // forward/self references (node2, node1 inside node1) must read 0
    prog(0, {5'd7, 5'd6, 5'd10});
    prog(1, {5'd1, 5'h18, 5'd9});
    prog(2, {5'h10, 5'd8, 5'd9});
    issue("three_node", 3, 1'b1, model_tt(3, 1'b1), 1'b0, 385);
    wait_drain("three_node");

    busy_seen = 1'b0;
    issue("nn0_illegal", 0, 1'b0, last_tt, 1'b1, 1);
    wait_drain("nn0_illegal");
    issue("nn9_illegal", 9, 1'b0, last_tt, 1'b1, 1);
    wait_drain("nn9_illegal");
    check("illegal_busy_never", 128'(busy_seen), 128'(0));

    // abort at cycle 50: back to IDLE with no done pulse
    prog(0, {5'd7, 5'd6, 5'd0});
    num_nodes = 4'd1;
    out_inv   = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("busy_before_abort", 128'(busy), 128'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 128'(busy), 128'(0));
    check("abort_partial_tt", 128'(tt[3:0]), 128'(4'hF));
    repeat (140) @(negedge clk);
    check("abort_stays_idle", 128'(busy), 128'(0));

    // reset at cycle 50 of a scan
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("pre_reset_partial_tt", 128'(tt[3:0]), 128'(4'hF));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_tt", tt, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) prog_mdl[i] = '0;
    repeat (300) @(negedge clk);
    check("post_reset_idle", 128'(busy), 128'(0));

    // program slots were cleared by reset: maj(0,0,0)=0, inverted -> all ones
    issue("after_reset", 1, 1'b1, {128{1'b1}}, 1'b0, 129);
    wait_drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
